// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NREQ requesters.
// Registered operands drive the ALU; its result is captured into a response register.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4,
    parameter int NREQ   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ*OP_W-1:0]   req_op,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [DATA_W-1:0]      alu_a,
    output logic [DATA_W-1:0]      alu_b,
    output logic [OP_W-1:0]        alu_op,
    input  logic [DATA_W-1:0]      alu_s,
    output logic                   busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     win;
    logic [PW-1:0]     idx;
    logic              any_valid;
    logic [NREQ-1:0]   win_oh;
    logic [NREQ-1:0]   owner_oh;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [OP_W-1:0]   sel_op;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PW'((int'(rr_ptr) + k) % NREQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                win       = idx;
            end
        end
    end

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_op   = '0;
        win_oh   = '0;
        owner_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                sel_a     = req_a[i*DATA_W +: DATA_W];
                sel_b     = req_b[i*DATA_W +: DATA_W];
                sel_op    = req_op[i*OP_W +: OP_W];
                win_oh[i] = 1'b1;
            end
            if (owner == PW'(i)) begin
                owner_oh[i] = 1'b1;
            end
        end
    end

    assign req_ready = (state == IDLE && any_valid) ? win_oh : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        alu_op <= sel_op;
                        owner  <= win;
                        rr_ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_s;
                    rsp_valid <= owner_oh;
                    state     <= RESP;
                end
                RESP: begin
                    // Only the owner's rsp_ready completes the handshake.
                    if (|(rsp_ready & owner_oh)) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
